// File: rtl/mul_share_ctrl_if.sv
// Request/response bundle between the calculator front-end requesters and mul_share_ctrl.
// The slave modport is the controller side; master is the requester/consumer side.
interface mul_share_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [3*NUM_REQ-1:0] req_a;
  logic [3*NUM_REQ-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [4:0]           rsp_product;
  logic                 rsp_zero;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_product, rsp_zero
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_product, rsp_zero
  );
endinterface

// File: rtl/mul_share_ctrl.sv
// Time-shares one sign-magnitude 3x3 multiplier between NUM_REQ requesters.
// Define MUL_SHARE_RR_EN for round-robin arbitration; otherwise lowest index wins.
//
// state | meaning
// IDLE  | waiting for a request; grant issued combinationally
// OPER  | operands registered on mul_a/mul_b, multiplier settling
// RESP  | product captured, holding rsp_* until rsp_ready
module mul_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mul_share_ctrl_if.slave      bus,
  output logic [2:0]           mul_a,
  output logic [2:0]           mul_b,
  input  logic [4:0]           mul_product,
  input  logic                 mul_zero,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, OPER, RESP} state_t;

  state_t             state_q, state_d;
  logic [2:0]         mul_a_q, mul_a_d;
  logic [2:0]         mul_b_q, mul_b_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [4:0]         rsp_product_q, rsp_product_d;
  logic               rsp_zero_q, rsp_zero_d;
  logic               rsp_valid_q, rsp_valid_d;

  logic [NUM_REQ-1:0] rot_valid;
  logic               gnt_found;
  logic [ID_W-1:0]    gnt_idx;
  logic               grant_en;
  logic [NUM_REQ-1:0] grant_vec;
  logic [2:0]         sel_a, sel_b;
  int                 scan;

`ifdef MUL_SHARE_RR_EN
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [2*NUM_REQ-1:0] dbl_valid;
`endif

  // Rotate the request vector so that bit 0 is the requester at ptr; the first
  // set bit then maps back to (ptr + k) mod NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = 0;
`ifdef MUL_SHARE_RR_EN
    dbl_valid = {bus.req_valid, bus.req_valid} >> ptr_q;
    rot_valid = dbl_valid[NUM_REQ-1:0];
`else
    rot_valid = bus.req_valid;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && rot_valid[k]) begin
        gnt_found = 1'b1;
`ifdef MUL_SHARE_RR_EN
        scan = int'(ptr_q) + k;
        if (scan >= NUM_REQ) scan = scan - NUM_REQ;
`else
        scan = k;
`endif
        gnt_idx = ID_W'(scan);
      end
    end
  end

  assign grant_en = (state_q == IDLE) && gnt_found && !rst;

  always_comb begin
    grant_vec = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (int'(gnt_idx) == k) begin
        grant_vec[k] = grant_en;
        sel_a        = bus.req_a[3*k +: 3];
        sel_b        = bus.req_b[3*k +: 3];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    rsp_id_d      = rsp_id_q;
    rsp_product_d = rsp_product_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_valid_d   = rsp_valid_q;
`ifdef MUL_SHARE_RR_EN
    ptr_d         = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          mul_a_d  = sel_a;
          mul_b_d  = sel_b;
          rsp_id_d = gnt_idx;
          state_d  = OPER;
`ifdef MUL_SHARE_RR_EN
          ptr_d    = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
`endif
        end
      end
      OPER: begin
        rsp_product_d = mul_product;
        rsp_zero_d    = mul_zero;
        rsp_valid_d   = 1'b1;
        state_d       = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
`ifdef MUL_SHARE_RR_EN
      ptr_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      rsp_id_q      <= rsp_id_d;
      rsp_product_q <= rsp_product_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_valid_q   <= rsp_valid_d;
`ifdef MUL_SHARE_RR_EN
      ptr_q         <= ptr_d;
`endif
    end
  end

  assign bus.req_ready   = grant_vec;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_product = rsp_product_q;
  assign bus.rsp_zero    = rsp_zero_q;
  assign mul_a           = mul_a_q;
  assign mul_b           = mul_b_q;
  assign busy            = (state_q != IDLE) && !rst;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Self-checking bench for mul_share_ctrl with a behavioural sign-magnitude multiplier.
// Grants push expected responses into a scoreboard; completed handshakes pop and compare.
module tb_mul_share_ctrl;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [4:0]      product;
    logic            zero;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [2:0] mul_a, mul_b;
  logic [4:0] mul_product;
  logic       mul_zero;
  logic       busy;
  logic [3:0] mag;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  exp_t sb[$];

  mul_share_ctrl_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  mul_share_ctrl #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_product (mul_product),
    .mul_zero    (mul_zero),
    .busy        (busy)
  );

  // Team multiplier: sign = xor of signs, magnitude = product of magnitudes.
  assign mag         = {2'b00, mul_a[1:0]} * {2'b00, mul_b[1:0]};
  assign mul_product = {mul_a[2] ^ mul_b[2], mag};
  assign mul_zero    = (mag == 4'd0);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t expect_rsp(input int id, input logic [2:0] a, input logic [2:0] b);
    exp_t e;
    int   m;
    m         = int'(a[1:0]) * int'(b[1:0]);
    e.id      = ID_W'(id);
    e.product = {a[2] ^ b[2], m[3:0]};
    e.zero    = (m == 0);
    return e;
  endfunction

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req_ready != '0) begin
        int g;
        g = onehot_idx(bus.req_ready);
        chk("grant_onehot", $countones(bus.req_ready), 1);
        sb.push_back(expect_rsp(g, bus.req_a[3*g +: 3], bus.req_b[3*g +: 3]));
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_id",      bus.rsp_id,      e.id);
          chk("sb_product", bus.rsp_product, e.product);
          chk("sb_zero",    bus.rsp_zero,    e.zero);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [2:0] a, input logic [2:0] b);
    bus.req_a[3*i +: 3] = a;
    bus.req_b[3*i +: 3] = b;
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    @(negedge clk);
    while (bus.req_ready == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, bus.req_ready != '0, 1);
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, bus.rsp_valid, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 0);
  endtask

  initial begin
    int   gnt_ids[5];
    int   gnt_cyc[5];
    int   exp_ids[5];
    int   ng;
    int   n;
    exp_t e5;

    // Reset with every requester pending.
    rst           = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_a     = 12'h5a5;
    bus.req_b     = 12'h3c3;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_busy",      busy, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_mul_a",     mul_a, 0);
    chk("rst_mul_b",     mul_b, 0);
    chk("rst_rsp_id",    bus.rsp_id, 0);
    step();
    rst           = 1'b0;
    bus.req_valid = '0;

    // Single request from requester 0: +3 * -2 = -6.
    step();
    set_op(0, 3'b011, 3'b110);
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("t2_req_ready", bus.req_ready, 4'b0001);
    chk("t2_busy_idle", busy, 0);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("t2_mul_a",        mul_a, 3'b011);
    chk("t2_mul_b",        mul_b, 3'b110);
    chk("t2_oper_valid",   bus.rsp_valid, 0);
    chk("t2_oper_busy",    busy, 1);
    chk("t2_oper_ready",   bus.req_ready, 0);
    step();
    @(negedge clk);
    chk("t2_rsp_valid",    bus.rsp_valid, 1);
    chk("t2_rsp_id",       bus.rsp_id, 0);
    chk("t2_rsp_product",  bus.rsp_product, 5'b10110);
    chk("t2_rsp_zero",     bus.rsp_zero, 0);
    step();
    @(negedge clk);
    chk("t2_back_idle",    busy, 0);
    chk("t2_valid_clear",  bus.rsp_valid, 0);
    chk("t2_mul_a_hold",   mul_a, 3'b011);

    // Zero-magnitude operand from requester 2.
    step();
    set_op(2, 3'b100, 3'b011);
    bus.req_valid = 4'b0100;
    wait_grant("t3_grant_timeout");
    step();
    bus.req_valid = '0;
    wait_rsp("t3_rsp_timeout");
    chk("t3_rsp_id",      bus.rsp_id, 2);
    chk("t3_rsp_product", bus.rsp_product, 5'b10000);
    chk("t3_rsp_zero",    bus.rsp_zero, 1);
    step();
    wait_idle("t3_idle_timeout");

    // Contention from a clean pointer.
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
`ifdef MUL_SHARE_RR_EN
    exp_ids = '{0, 1, 2, 3, 0};
`else
    exp_ids = '{0, 0, 0, 0, 0};
`endif
    ng = 0;
    n  = 0;
    while (ng < 5 && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.req_ready != '0) begin
        gnt_ids[ng] = onehot_idx(bus.req_ready);
        gnt_cyc[ng] = cyc;
        ng++;
      end
    end
    chk("t4_grant_count", ng, 5);
    step();
    bus.req_valid = '0;
    for (int i = 0; i < ng; i++) begin
      chk($sformatf("t4_grant_%0d", i), gnt_ids[i], exp_ids[i]);
      if (i > 0) chk($sformatf("t4_spacing_%0d", i), gnt_cyc[i] - gnt_cyc[i-1], 3);
    end
    wait_idle("t4_idle_timeout");

    // Backpressure on requester 1 while requester 3 waits.
    step();
    bus.rsp_ready = 1'b0;
    set_op(1, 3'b111, 3'b010);
    set_op(3, 3'b001, 3'b101);
    e5 = expect_rsp(1, 3'b111, 3'b010);
    bus.req_valid = 4'b0010;
    wait_grant("t5_grant_timeout");
    chk("t5_grant", bus.req_ready, 4'b0010);
    step();
    bus.req_valid = 4'b1000;
    wait_rsp("t5_rsp_timeout");
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      chk($sformatf("t5_hold_valid_%0d", i), bus.rsp_valid, 1);
      chk($sformatf("t5_hold_prod_%0d", i),  bus.rsp_product, e5.product);
      chk($sformatf("t5_hold_id_%0d", i),    bus.rsp_id, e5.id);
      chk($sformatf("t5_hold_ready_%0d", i), bus.req_ready, 0);
      chk($sformatf("t5_hold_busy_%0d", i),  busy, 1);
    end
    step();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("t5_hs_valid", bus.rsp_valid, 1);
    step();
    @(negedge clk);
    chk("t5_idle_busy",   busy, 0);
    chk("t5_next_grant",  bus.req_ready, 4'b1000);
    step();
    bus.req_valid = '0;
    wait_rsp("t5b_rsp_timeout");
    chk("t5b_rsp_id", bus.rsp_id, 3);
    step();
    wait_idle("t5_idle_timeout");

    // Reset while requester 1 is in OPER.
    step();
    set_op(1, 3'b010, 3'b011);
    bus.req_valid = 4'b0010;
    wait_grant("t6_grant_timeout");
    step();
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("t6_rst_busy",  busy, 0);
    chk("t6_rst_ready", bus.req_ready, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rsp_valid", bus.rsp_valid, 0);
    chk("t6_mul_a",     mul_a, 0);
    chk("t6_regrant",   bus.req_ready, 4'b0010);
    step();
    bus.req_valid = '0;
    wait_rsp("t6_rsp_timeout");
    chk("t6_rsp_product", bus.rsp_product, 5'b00110);
    step();
    wait_idle("t6_idle_timeout");

    repeat (3) step();
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
